div_ctrl: RTL and testbench
===========================

# div_ctrl

EX-stage sequencer for the multi-cycle radix-2 divider. Accepts one DIV/DIVU per request from the EX stage, latches operands, drives the divider's start/annul/signed/operand inputs, and holds the pipeline stall request until the quotient/remainder return. It writes HI/LO with a one-cycle strobe, cancels cleanly on pipeline flush, and flags a hung divider via a watchdog.

## Interface
- TIMEOUT, 48: BUSY cycles without div_ready_i before watchdog abort (must exceed 36).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  1  EX holds a DIV/DIVU this cycle.
- signed_i  in  1  1 = DIV, 0 = DIVU.
- op1_i  in  32  dividend.
- op2_i  in  32  divisor.
- flush_i  in  1  pipeline flush; kills the in-flight division.
- div_result_i  in  64  {remainder, quotient} from divider.
- div_ready_i  in  1  divider result valid.
- div_start_o  out  1  start to divider (registered).
- div_annul_o  out  1  annul to divider (registered).
- div_signed_o  out  1  latched signed_i.
- div_op1_o  out  32  latched op1_i.
- div_op2_o  out  32  latched op2_i.
- stallreq_o  out  1  stall request to pipeline control (combinational).
- whilo_o  out  1  HI/LO write strobe, one cycle (combinational).
- hi_o  out  32  div_result_i[63:32] (remainder).
- lo_o  out  32  div_result_i[31:0] (quotient).
- timeout_o  out  1  sticky watchdog error; cleared only by rst.

## Operation
- States: IDLE, BUSY, DONE, CANCEL. Reset: IDLE; div_start_o=0, div_annul_o=0, div_signed_o=0, div_op1_o=0, div_op2_o=0, timeout_o=0, wdog=0, cancel count=0.
- IDLE: req_i & !flush_i -> latch operands/signed, div_start_o<=1, wdog<=0, go BUSY; stallreq_o=1 this cycle. req_i & flush_i -> stay IDLE, no stall.
- BUSY: div_start_o=1, stallreq_o=1 while div_ready_i=0; wdog increments.
  - div_ready_i=1 & !flush_i: whilo_o=1, stallreq_o=0, hi_o/lo_o = div_result_i, div_start_o<=0, go DONE.
  - flush_i (priority over ready): no write, stallreq_o=0, div_start_o<=0, div_annul_o<=1, go CANCEL.
  - wdog==TIMEOUT-1 with no ready: timeout_o<=1, stallreq_o=0, no write, go CANCEL.
- DONE: div_start_o=0; wait for divider to drop ready. div_ready_i=0 -> IDLE. req_i here -> stallreq_o=1, not accepted until IDLE.
- CANCEL: div_start_o=0, div_annul_o=1; fixed 3 cycles (covers divider's div-by-zero and end states returning to free), then div_annul_o<=0, IDLE. div_ready_i ignored; whilo_o=0; req_i -> stallreq_o=1.
- whilo_o only in BUSY; hi_o/lo_o are don't-care when whilo_o=0 (pass-through).
- Divide-by-zero: no special casing; divider returns 0, written as HI=LO=0.
- Latched operands stable from BUSY entry until IDLE re-entry; op changes on req_i ignored.
- rst in any state -> IDLE next edge, all outputs to reset values.

## Timing
- Request in cycle T (IDLE): div_start_o=1 from T+1.
- Nonzero divisor: div_ready_i first high in T+36; whilo_o=1 and stallreq_o=0 in T+36; DONE T+37..T+38; IDLE T+39.
- Zero divisor: ready in T+4, whilo_o in T+4, zeros written.
- Back-to-back divisions: next accepted no earlier than 3 cycles after the write cycle.
- Flush in BUSY cycle F: div_annul_o=1 in F+1..F+3, IDLE at F+4; no whilo_o from F on.
- Watchdog: entry to CANCEL after TIMEOUT BUSY cycles with no ready.

## Test plan
- DIVU 100/7, req at T -> whilo_o=1 only at T+36, lo_o=14, hi_o=2; stallreq_o=1 T..T+35.
- DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 7/-2 -> lo_o=0xFFFFFFFD, hi_o=1.
- DIV 5/0 at T -> whilo_o at T+4, hi_o=lo_o=0; IDLE by T+7.
- flush_i at T+10 of 100/7 -> no whilo_o ever; div_annul_o=1 T+11..T+13; new 9/3 at T+14 -> lo_o=3, hi_o=0 at T+50.
- flush_i same cycle div_ready_i=1 -> whilo_o=0, state CANCEL.
- Tie div_ready_i=0 -> timeout_o=1 after 48 BUSY cycles, stallreq_o drops, stays sticky until rst; rst mid-BUSY -> all outputs reset next cycle.

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for the multi-cycle radix-2 divider
module div_ctrl #(
    parameter int TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o
);
    localparam int WW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, BUSY, DONE, CANCEL} state_t;
    state_t state, state_n;
    logic [WW-1:0] wdog, wdog_n;
    logic [1:0] cnt, cnt_n;
    logic start_n, annul_n, signed_n, timeout_n;
    logic [31:0] op1_n, op2_n;
    assign hi_o = div_result_i[63:32];
    assign lo_o = div_result_i[31:0];
    // state and latched divider controls
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div_start_o  <= 1'b0;
            div_annul_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            timeout_o    <= 1'b0;
            wdog         <= '0;
            cnt          <= '0;
        end else begin
            state        <= state_n;
            div_start_o  <= start_n;
            div_annul_o  <= annul_n;
            div_signed_o <= signed_n;
            div_op1_o    <= op1_n;
            div_op2_o    <= op2_n;
            timeout_o    <= timeout_n;
            wdog         <= wdog_n;
            cnt          <= cnt_n;
        end
    end
    // next state, stall and HI/LO strobe; flush outranks ready, ready outranks the watchdog
    always_comb begin
        state_n    = state;
        start_n    = div_start_o;
        annul_n    = div_annul_o;
        signed_n   = div_signed_o;
        op1_n      = div_op1_o;
        op2_n      = div_op2_o;
        timeout_n  = timeout_o;
        wdog_n     = wdog;
        cnt_n      = cnt;
        stallreq_o = 1'b0;
        whilo_o    = 1'b0;
        case (state)
            IDLE: begin
                if (req_i && !flush_i) begin
                    signed_n   = signed_i;
                    op1_n      = op1_i;
                    op2_n      = op2_i;
                    start_n    = 1'b1;
                    wdog_n     = '0;
                    stallreq_o = 1'b1;
                    state_n    = BUSY;
                end
            end
            BUSY: begin
                wdog_n = wdog + 1'b1;
                if (flush_i) begin
                    start_n = 1'b0;
                    annul_n = 1'b1;
                    cnt_n   = '0;
                    state_n = CANCEL;
                end else if (div_ready_i) begin
                    whilo_o = 1'b1;
                    start_n = 1'b0;
                    state_n = DONE;
                end else if (wdog == WW'(TIMEOUT - 1)) begin
                    timeout_n = 1'b1;
                    start_n   = 1'b0;
                    annul_n   = 1'b1;
                    cnt_n     = '0;
                    state_n   = CANCEL;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
            DONE: begin
                stallreq_o = req_i;
                state_n    = div_ready_i ? DONE : IDLE;
            end
            CANCEL: begin
                stallreq_o = req_i;
                cnt_n      = cnt + 2'd1;
                if (cnt == 2'd2) begin
                    annul_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl with a behavioural divider and result scoreboard
module tb_div_ctrl;
    logic        clk = 1'b0;
    logic        rst, req_i, signed_i, flush_i, div_ready_i;
    logic [31:0] op1_i, op2_i;
    logic [63:0] div_result_i;
    logic        div_start_o, div_annul_o, div_signed_o, stallreq_o, whilo_o, timeout_o;
    logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;
    div_ctrl #(.TIMEOUT(48)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .signed_i(signed_i), .op1_i(op1_i), .op2_i(op2_i),
        .flush_i(flush_i), .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .stallreq_o(stallreq_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o), .timeout_o(timeout_o)
    );
    always #5 clk = ~clk;
    // behavioural divider: ready after 35 start cycles (3 for zero divisor), held one cycle past start
    logic [7:0] bcnt;
    logic       hold, hang, lat_hit;
    function automatic logic [63:0] dmodel(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return '0;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction
    assign lat_hit      = div_start_o && !div_annul_o && !hang && (bcnt >= ((div_op2_o == 32'd0) ? 8'd3 : 8'd35));
    assign div_ready_i  = lat_hit || hold;
    assign div_result_i = dmodel(div_signed_o, div_op1_o, div_op2_o);
    always @(posedge clk) begin
        bcnt <= (rst || !div_start_o || div_annul_o) ? 8'd0 : bcnt + 8'd1;
        hold <= rst ? 1'b0 : lat_hit;
    end
    typedef struct {
        logic        s;
        logic [31:0] a, b, hi, lo;
        int          lat;
    } vec_t;
    vec_t tbl[7];
    logic [63:0] exp_q[$];
    int n_checks = 0, n_fail = 0, cyc = 0, last_w = -1;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic smp();
        logic [63:0] e;
        @(negedge clk);
        if (whilo_o) begin
            last_w = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL whilo_unexpected: got whilo_o=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("hi", {32'd0, hi_o}, {32'd0, e[63:32]});
                chk("lo", {32'd0, lo_o}, {32'd0, e[31:0]});
            end
        end
    endtask
    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic start_req(input logic s, input logic [31:0] a, input logic [31:0] b);
        req_i = 1'b1; signed_i = s; op1_i = a; op2_i = b;
        smp();
        chk("req_stall", 64'(stallreq_o), 64'd1);
        chk("req_start_low", 64'(div_start_o), 64'd0);
        chk("req_annul_low", 64'(div_annul_o), 64'd0);
        adv();
        req_i = 1'b0; signed_i = ~s; op1_i = $urandom; op2_i = $urandom;
    endtask
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input int lat);
        int t0;
        t0 = cyc;
        last_w = -1;
        exp_q.push_back({ehi, elo});
        start_req(s, a, b);
        for (int k = 1; k <= lat + 2; k++) begin
            req_i = (k > lat);
            smp();
            if (k == 1) begin
                chk("start", 64'(div_start_o), 64'd1);
                chk("op1_latched", 64'(div_op1_o), 64'(a));
                chk("op2_latched", 64'(div_op2_o), 64'(b));
                chk("signed_latched", 64'(div_signed_o), 64'(s));
            end
            if (k == 1 || k == lat - 1) chk("busy_stall", 64'(stallreq_o), 64'd1);
            if (k == lat) chk("write_stall", 64'(stallreq_o), 64'd0);
            if (k > lat) chk("done_req_stall", 64'(stallreq_o), 64'd1);
            if (k == lat + 2) chk("done_not_accepted", 64'(div_start_o), 64'd0);
            adv();
        end
        req_i = 1'b0;
        chk("whilo_cycle", 64'(last_w - t0), 64'(lat));
    endtask
    initial begin
        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         36};
        tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   36};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   36};
        tbl[3] = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd0,          4};
        tbl[4] = '{1'b0, 32'hFFFFFFFF,   32'd16,         32'd15,         32'h0FFFFFFF,   36};
        tbl[5] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   32'd14,         36};
        tbl[6] = '{1'b0, 32'd0,          32'd0,          32'd0,          32'd0,          4};
        rst = 1'b1; req_i = 1'b0; signed_i = 1'b0; op1_i = '0; op2_i = '0; flush_i = 1'b0; hang = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        smp();
        chk("rst_start", 64'(div_start_o), 64'd0);
        chk("rst_annul", 64'(div_annul_o), 64'd0);
        chk("rst_op1", 64'(div_op1_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        chk("rst_stall", 64'(stallreq_o), 64'd0);
        rst = 1'b0;
        adv();
        for (int i = 0; i < 7; i++) run_div(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].lat);
        req_i = 1'b1; flush_i = 1'b1; op1_i = 32'd9; op2_i = 32'd3;
        smp();
        chk("req_flush_stall", 64'(stallreq_o), 64'd0);
        adv();
        req_i = 1'b0; flush_i = 1'b0;
        smp();
        chk("req_flush_no_start", 64'(div_start_o), 64'd0);
        adv();
        start_req(1'b0, 32'd100, 32'd7);
        for (int k = 1; k <= 13; k++) begin
            flush_i = (k == 10);
            smp();
            if (k == 10) chk("flush_stall", 64'(stallreq_o), 64'd0);
            if (k >= 11) chk("flush_annul", 64'(div_annul_o), 64'd1);
            if (k >= 11) chk("flush_start", 64'(div_start_o), 64'd0);
            adv();
        end
        flush_i = 1'b0;
        run_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 36);
        start_req(1'b0, 32'd100, 32'd7);
        for (int k = 1; k <= 40; k++) begin
            flush_i = (k == 36);
            smp();
            if (k == 36) chk("flush_ready_ready", 64'(div_ready_i), 64'd1);
            if (k == 36) chk("flush_ready_stall", 64'(stallreq_o), 64'd0);
            if (k >= 37 && k <= 39) chk("flush_ready_annul", 64'(div_annul_o), 64'd1);
            if (k == 40) chk("flush_ready_annul_end", 64'(div_annul_o), 64'd0);
            adv();
        end
        flush_i = 1'b0;
        hang = 1'b1;
        start_req(1'b1, 32'd50, 32'd5);
        for (int k = 1; k <= 60; k++) begin
            smp();
            if (k == 47) chk("wdog_stall_before", 64'(stallreq_o), 64'd1);
            if (k == 48) chk("wdog_stall_drop", 64'(stallreq_o), 64'd0);
            if (k == 48) chk("wdog_timeout_before", 64'(timeout_o), 64'd0);
            if (k == 49) chk("wdog_timeout", 64'(timeout_o), 64'd1);
            if (k == 49) chk("wdog_annul", 64'(div_annul_o), 64'd1);
            if (k == 52) chk("wdog_annul_end", 64'(div_annul_o), 64'd0);
            if (k == 60) chk("wdog_sticky", 64'(timeout_o), 64'd1);
            adv();
        end
        hang = 1'b0;
        run_div(1'b0, 32'd81, 32'd9, 32'd0, 32'd9, 36);
        smp();
        chk("timeout_sticky_after_div", 64'(timeout_o), 64'd1);
        adv();
        start_req(1'b1, 32'h12345678, 32'd3);
        for (int k = 1; k <= 6; k++) begin
            rst = (k == 5);
            smp();
            if (k == 6) begin
                chk("midrst_start", 64'(div_start_o), 64'd0);
                chk("midrst_signed", 64'(div_signed_o), 64'd0);
                chk("midrst_op1", 64'(div_op1_o), 64'd0);
                chk("midrst_op2", 64'(div_op2_o), 64'd0);
                chk("midrst_timeout", 64'(timeout_o), 64'd0);
                chk("midrst_stall", 64'(stallreq_o), 64'd0);
            end
            adv();
        end
        rst = 1'b0;
        run_div(1'b1, 32'hFFFFFFF9, 32'd7, 32'd0, 32'hFFFFFFFF, 36);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
